// File: rtl/mealy_seq_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// latency: n/a (constants only); backpressure: n/a.
// KMP next-state table is built from these functions at elaboration.
package mealy_seq_pkg;

  typedef enum logic [1:0] {EV_IDLE, EV_CLEAR, EV_STEP} ev_t;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int state_w(input int pat_w);
    return (clog2(pat_w) < 1) ? 1 : clog2(pat_w);
  endfunction

  // s[j] is the j-th received bit: the k matched prefix bits followed by b.
  // Result is the longest pattern prefix (shorter than the pattern) ending s.
  function automatic int kmp_next(input logic [15:0] pat, input int pat_w,
                                  input int k, input logic b, input int overlap);
    logic [16:0] s;
    int          lmax;
    int          res;
    bit          ok;
    s = '0;
    for (int j = 0; j < 16; j++)
      if (j < k) s[j] = pat[pat_w-1-j];
    s[k] = b;
    if ((k == pat_w - 1) && (b == pat[0]) && (overlap == 0)) return 0;
    lmax = (k + 1 < pat_w) ? k + 1 : pat_w - 1;
    res  = 0;
    for (int l = 16; l >= 1; l--) begin
      if (l <= lmax && res == 0) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
          if (i < l && s[k+1-l+i] != pat[pat_w-1-i]) ok = 1'b0;
        if (ok) res = l;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mealy_seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// latency: count reflects inc/clr one cycle later; backpressure: none.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + W'(1);
  end

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector (KMP transitions); counter built only with MEALY_SEQ_MATCH_CNT_EN.
// latency: match 0 cycles, match_r/match_count 1 cycle; backpressure: din_valid low holds state.
module mealy_seq_detector
  import mealy_seq_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      din_valid,
  input  logic                      din,
  input  logic                      clear,
  output logic                      match,
  output logic                      match_r,
  output logic [CNT_W-1:0]          match_count,
  output logic [state_w(PAT_W)-1:0] state_o
);

  localparam int SW   = state_w(PAT_W);
  localparam int NST  = 1 << SW;
  localparam int LAST = PAT_W - 1;

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("mealy_seq_detector: PAT_W out of range 2..16");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("mealy_seq_detector: CNT_W out of range 1..32");
  end

  logic [SW-1:0] state, state_nxt;
  logic [SW-1:0] nxt0 [NST];
  logic [SW-1:0] nxt1 [NST];
  ev_t           ev;

  // Unreachable encodings (non power-of-two PAT_W) fall back to state 0.
  for (genvar k = 0; k < NST; k++) begin : g_nxt
    if (k < PAT_W) begin : g_v
      localparam int N0 = kmp_next(16'(PATTERN), PAT_W, k, 1'b0, OVERLAP);
      localparam int N1 = kmp_next(16'(PATTERN), PAT_W, k, 1'b1, OVERLAP);
      assign nxt0[k] = SW'(N0);
      assign nxt1[k] = SW'(N1);
    end else begin : g_u
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= '0;
      match_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      match_r <= match;
    end
  end

  always_comb begin
    ev        = EV_IDLE;
    state_nxt = state;
    match     = 1'b0;
    if (clear)          ev = EV_CLEAR;
    else if (din_valid) ev = EV_STEP;
    case (ev)
      EV_CLEAR: state_nxt = '0;
      EV_STEP: begin
        match     = (state == SW'(LAST)) && (din == PATTERN[0]);
        state_nxt = din ? nxt1[state] : nxt0[state];
      end
      default: ;
    endcase
  end

  assign state_o = state;

`ifdef MEALY_SEQ_MATCH_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (clear),
    .count (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Bench for mealy_seq_detector: five configurations share one directed stream.
// A stream-history model checks every cycle; literal checks pin key points.
module tb_mealy_seq_detector;

`ifdef MEALY_SEQ_MATCH_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic clear = 1'b0;

  logic       m_o  [5];
  logic       mr_o [5];
  logic [1:0] st_o [5];
  logic [7:0] c0, c1, c2, c3;
  logic [1:0] c4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // 0: 1011 overlap, 1: 1011 non-overlap, 2: 111 overlap, 3: 111 non-overlap, 4: 1011 CNT_W=2
  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear(clear),
    .match(m_o[0]), .match_r(mr_o[0]), .match_count(c0), .state_o(st_o[0]));
  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear(clear),
    .match(m_o[1]), .match_r(mr_o[1]), .match_count(c1), .state_o(st_o[1]));
  mealy_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear(clear),
    .match(m_o[2]), .match_r(mr_o[2]), .match_count(c2), .state_o(st_o[2]));
  mealy_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(0), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear(clear),
    .match(m_o[3]), .match_r(mr_o[3]), .match_count(c3), .state_o(st_o[3]));
  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(2)) dut4 (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din), .clear(clear),
    .match(m_o[4]), .match_r(mr_o[4]), .match_count(c4), .state_o(st_o[4]));

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per config, the consumed bits since the last restart point.
  int          pw  [5] = '{4, 4, 3, 3, 4};
  int unsigned pt  [5] = '{11, 11, 7, 7, 11};
  int          ov  [5] = '{1, 0, 1, 0, 1};
  int unsigned cmx [5] = '{255, 255, 255, 255, 3};
  int unsigned hist [5] = '{default: 0};
  int          len  [5] = '{default: 0};
  int unsigned ecnt [5] = '{default: 0};
  int          emr  [5] = '{default: 0};

  function automatic int exp_state(input int d);
    for (int k = 15; k > 0; k--)
      if (k < pw[d] && k <= len[d] &&
          (hist[d] & ((32'd1 << k) - 1)) == (pt[d] >> (pw[d] - k)))
        return k;
    return 0;
  endfunction

  function automatic int act_cnt(input int d);
    case (d)
      0: return int'(c0);
      1: return int'(c1);
      2: return int'(c2);
      3: return int'(c3);
      default: return int'(c4);
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < 5; d++) begin
        int es, em;
        es = reset ? 0 : exp_state(d);
        em = (!reset && din_valid && !clear && (len[d] + 1 >= pw[d]) &&
              ((((hist[d] << 1) | int'(din)) & ((32'd1 << pw[d]) - 1)) == pt[d])) ? 1 : 0;
        chk($sformatf("d%0d.match", d), int'(m_o[d]), em);
        chk($sformatf("d%0d.state_o", d), int'(st_o[d]), es);
        chk($sformatf("d%0d.match_r", d), int'(mr_o[d]), reset ? 0 : emr[d]);
        chk($sformatf("d%0d.match_count", d), act_cnt(d), reset ? 0 : int'(ecnt[d]) * CNT_ON);
        if (reset || clear) begin
          hist[d] = 0; len[d] = 0; ecnt[d] = 0; emr[d] = 0;
        end else if (din_valid) begin
          emr[d] = em;
          if (em == 1 && ecnt[d] < cmx[d]) ecnt[d]++;
          hist[d] = (hist[d] << 1) | int'(din);
          if (len[d] < 16) len[d]++;
          if (em == 1 && ov[d] == 0) len[d] = 0;
        end else begin
          emr[d] = 0;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge clk);
    #1;
    din_valid = v; din = b; clear = c;
  endtask

  logic [15:0] vec;

  initial begin
    repeat (2) @(negedge clk);
    #2;
    chk("reset.state_o", int'(st_o[0]), 0);
    chk("reset.match_r", int'(mr_o[0]), 0);
    chk("reset.match_count", int'(c0), 0);
    @(negedge clk); #1; reset = 1'b0;

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    vec = 16'b1011011;
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, vec[i], 1'b0);
      #1;
      if (i == 3) begin
        chk("ov1.bit4.match", int'(m_o[0]), 1);
        chk("ov0.bit4.match", int'(m_o[1]), 1);
      end
      if (i == 0) begin
        chk("ov1.bit7.match", int'(m_o[0]), 1);
        chk("ov0.bit7.match", int'(m_o[1]), 0);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("ov1.count", int'(c0), 2 * CNT_ON);
    chk("ov0.count", int'(c1), 1 * CNT_ON);
    chk("ov0.state_o", int'(st_o[1]), 1);
    chk("ov1.match_r", int'(mr_o[0]), 1);
    drive(1'b0, 1'b0, 1'b1);

    // 111 detector with five 1s
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      #1;
      chk($sformatf("p111ov1.bit%0d.match", i), int'(m_o[2]), (i >= 3) ? 1 : 0);
      chk($sformatf("p111ov0.bit%0d.match", i), int'(m_o[3]), (i == 3) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 1'b1);

    // Gap with din_valid low while sitting in the last state
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      #1;
      chk("gap.state_o", int'(st_o[0]), 3);
      chk("gap.match", int'(m_o[0]), 0);
    end
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("resume.match", int'(m_o[0]), 1);
    drive(1'b0, 1'b0, 1'b1);

    // Five overlapping matches into a 2-bit counter, then clear with a final bit pending
    vec = 16'b1011011011011011;
    for (int i = 15; i >= 0; i--) drive(1'b1, vec[i], 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    #1;
    chk("sat.count", int'(c4), 3 * CNT_ON);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    #1;
    chk("clear.match_forced", int'(m_o[0]), 0);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("clear.count", int'(c4), 0);
    chk("clear.state_o", int'(st_o[4]), 0);

    // Reset mid-pattern discards the partial match
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst.count_async", int'(c0), 0);
    chk("rst.state_async", int'(st_o[0]), 0);
    @(negedge clk); #1; reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    #1;
    chk("rst.no_match", int'(m_o[0]), 0);
    drive(1'b0, 1'b0, 1'b0);
    #1;
    chk("rst.state_o", int'(st_o[0]), 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mealy_seq_detector.md
MEALY_SEQ_DETECTOR -- requirements
Module: mealy_seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011: PAT_W-bit target sequence, MSB received first.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: width of match counter, legal range 1..32.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 din_valid  input  1  qualifies din; the bit is consumed on a clk edge only when high.
REQ-008 din  input  1  serial data bit.
REQ-009 clear  input  1  synchronous restart of detection and counter.
REQ-010 match  output  1  Mealy output; high in the cycle the final pattern bit is presented.
REQ-011 match_r  output  1  match registered; high one cycle after match.
REQ-012 match_count  output  CNT_W  saturating count of detected matches.
REQ-013 state_o  output  clog2(PAT_W)  current state, for debug.

Function
REQ-014 State k (0..PAT_W-1) SHALL mean the last k consumed bits equal PATTERN[PAT_W-1 -: k].
REQ-015 match SHALL equal din_valid & ~clear & (state == PAT_W-1) & (din == PATTERN[0]), combinationally, no latch.
REQ-016 On a consumed bit that extends the prefix, state SHALL become k+1.
REQ-017 On mismatch at state k, next state SHALL be the longest pattern prefix that is a suffix of (matched k bits followed by din), computed at elaboration (KMP failure).
REQ-018 On match with OVERLAP=1, next state SHALL be the longest proper prefix of PATTERN that is also its suffix; with OVERLAP=0, next state SHALL be 0.
REQ-019 With din_valid low, state, counter and match_r SHALL hold, except that match_r SHALL clear to 0.
REQ-020 clear high SHALL set state to 0 and match_count to 0 at the next edge, overriding din_valid; match is forced to 0.
REQ-021 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1, with no wrap.
REQ-022 Latency: match is 0 cycles from the final bit; match_r and match_count update 1 cycle after it.

Reset
REQ-023 reset high SHALL asynchronously force state=0, match_r=0 and match_count=0; match is then 0 because the state is 0.
REQ-024 Reset mid-pattern SHALL discard the partial match; detection restarts from the first bit after reset deasserts.

Configuration
REQ-025 Macro MEALY_SEQ_MATCH_CNT_EN defined: the counter and its saturation logic SHALL be built as per REQ-021.
REQ-026 Macro MEALY_SEQ_MATCH_CNT_EN undefined: no counter flops SHALL exist, and match_count SHALL be tied to 0; all other behaviour is unchanged.

Structure
REQ-027 Package mealy_seq_pkg SHALL hold the clog2 function, the state-width constant derivation and the elaboration-time KMP failure/next-state function.
REQ-028 Sub-module sat_counter (parametrised width, inc, clr, async reset) SHALL implement match_count, instantiated only under MEALY_SEQ_MATCH_CNT_EN.
REQ-029 Elaboration SHALL fail if PAT_W or CNT_W is out of range.

Verification
REQ-030 PATTERN=4'b1011, OVERLAP=1, din_valid=1, stream 1,0,1,1,0,1,1 -> match on bits 4 and 7, match_count=2.
REQ-031 Same pattern, OVERLAP=0, same stream -> match on bit 4 only, match_count=1, state_o=1 after bit 7.
REQ-032 PAT_W=3, PATTERN=3'b111, OVERLAP=1, five 1s -> match on bits 3,4,5; with OVERLAP=0 -> match on bit 3 only.
REQ-033 Stream 1,0,1 then din_valid=0 for 3 cycles then 1 -> state_o holds 3 during the gap, match on the resumed bit, match=0 during the gap.
REQ-034 CNT_W=2 with 5 matches -> match_count=3 (saturated); clear pulse -> match_count=0 and state_o=0 next edge.
REQ-035 Stream 1,0,1, reset pulse mid-cycle, then 1 -> match_count=0 immediately, no match on the 1, state_o=1.
